// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Two-requester UART transmitter (8N1). Arbitrates between two byte
//   sources and sends the winner's byte on tx_o. A tie goes to whichever
//   requester did not win the previous grant. The bit period comes from a
//   divisor that is picked from the requested baud rate when the grant is
//   made, so a baud change only takes effect on the next frame.
//
// Ports
//   clk_i        system clock, all state on its rising edge
//   rst_i        asynchronous active-high reset
//   baud_rate_i  requested baud rate in bit/s, sampled at grant
//   req_i        per-requester level request, held until acked
//   data0_i      requester 0 byte
//   data1_i      requester 1 byte
//   ack_o        one-cycle pulse, byte of that requester latched
//   done_o       one-cycle pulse, stop bit of the frame completed
//   done_id_o    requester index of the frame flagged by done_o
//   busy_o       high while a frame is in progress
//   tx_o         serial line, idle high
module uart_tx_sched (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [16:0] baud_rate_i,
  input  logic [1:0]  req_i,
  input  logic [7:0]  data0_i,
  input  logic [7:0]  data1_i,
  output logic [1:0]  ack_o,
  output logic        done_o,
  output logic        done_id_o,
  output logic        busy_o,
  output logic        tx_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  localparam logic [13:0] DIV_DEFAULT = 14'd5208;

  // Clock cycles per bit for a 50 MHz system clock; unknown rates fall
  // back to the 9600 bit/s divisor.
  function automatic logic [13:0] baud_to_div(input logic [16:0] baud);
    logic [13:0] div;
    case (baud)
      17'd4800:  div = 14'd10416;
      17'd9600:  div = 14'd5208;
      17'd14400: div = 14'd3472;
      17'd19200: div = 14'd2604;
      17'd38400: div = 14'd1302;
      17'd57600: div = 14'd868;
      default:   div = DIV_DEFAULT;
    endcase
    return div;
  endfunction

  state_t      state_q, state_d;
  logic [13:0] cnt_q, cnt_d;
  logic [13:0] div_q, div_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic [1:0]  ack_q, ack_d;
  logic        done_q, done_d;
  logic        done_id_q, done_id_d;
  logic        id_q, id_d;
  logic        last_q, last_d;

  logic        bit_end;
  logic        gnt_id;

  assign bit_end = (cnt_q == div_q - 14'd1);

  // Lone request wins outright; on a tie the loser of the last grant wins.
  assign gnt_id = (req_i == 2'b11) ? ~last_q : req_i[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    ack_d     = 2'b00;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    id_d      = id_q;
    last_d    = last_q;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (req_i != 2'b00) begin
          state_d         = S_START;
          tx_d            = 1'b0;
          cnt_d           = 14'd0;
          bit_idx_d       = 3'd0;
          shift_d         = gnt_id ? data1_i : data0_i;
          div_d           = baud_to_div(baud_rate_i);
          ack_d[gnt_id]   = 1'b1;
          id_d            = gnt_id;
          last_d          = gnt_id;
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          cnt_d     = 14'd0;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end else begin
          cnt_d = cnt_q + 14'd1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          cnt_d = 14'd0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[bit_idx_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + 14'd1;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          state_d   = S_IDLE;
          cnt_d     = 14'd0;
          bit_idx_d = 3'd0;
          done_d    = 1'b1;
          done_id_d = id_q;
        end else begin
          cnt_d = cnt_q + 14'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        cnt_d   = 14'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= 14'd0;
      div_q     <= DIV_DEFAULT;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
      ack_q     <= 2'b00;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      id_q      <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      id_q      <= id_d;
      last_q    <= last_d;
    end
  end

  assign ack_o     = ack_q;
  assign done_o    = done_q;
  assign done_id_o = done_id_q;
  assign busy_o    = (state_q != S_IDLE);
  assign tx_o      = tx_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;

  logic        clk;
  logic        rst;
  logic [16:0] baud;
  logic [1:0]  req;
  logic [7:0]  data0;
  logic [7:0]  data1;
  logic [1:0]  ack;
  logic        done;
  logic        done_id;
  logic        busy;
  logic        tx;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  uart_tx_sched dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .baud_rate_i (baud),
    .req_i       (req),
    .data0_i     (data0),
    .data1_i     (data1),
    .ack_o       (ack),
    .done_o      (done),
    .done_id_o   (done_id),
    .busy_o      (busy),
    .tx_o        (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant + full frame. Called with req already set; returns in the first
  // IDLE cycle after the stop bit.
  task automatic frame(input string tag, input int id, input logic [7:0] d,
                       input int div, input logic [16:0] baud_after,
                       input bit pulse1);
    logic [9:0] pat;
    logic [1:0] exp_ack;
    bit ok;
    bit quiet;
    pat     = {1'b1, d, 1'b0};
    exp_ack = 2'b01 << id;
    ok      = 1'b1;
    quiet   = 1'b1;
    tick();
    chk({tag, " ack"}, {30'd0, ack}, {30'd0, exp_ack});
    chk({tag, " busy"}, {31'd0, busy}, 32'd1);
    req[id] = 1'b0;
    baud    = baud_after;
    for (int s = 0; s < 10; s++) begin
      for (int c = 0; c < div; c++) begin
        if (tx !== pat[s]) ok = 1'b0;
        if (!(s == 0 && c == 0) && (ack !== 2'b00 || done !== 1'b0)) quiet = 1'b0;
        if (pulse1 && s == 1 && c == 0) req[1] = 1'b1;
        if (pulse1 && s == 1 && c == 5) req[1] = 1'b0;
        tick();
      end
    end
    chk({tag, " waveform"}, {31'd0, ok}, 32'd1);
    chk({tag, " quiet"}, {31'd0, quiet}, 32'd1);
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " done_id"}, {31'd0, done_id}, id);
    chk({tag, " idle busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " idle tx"}, {31'd0, tx}, 32'd1);
  endtask

  // Grant then count start-bit cycles (data bit 0 must be 1).
  task automatic start_len(input string tag, input int id, input int exp_div);
    int n;
    logic [1:0] exp_ack;
    exp_ack = 2'b01 << id;
    n = 0;
    tick();
    chk({tag, " ack"}, {30'd0, ack}, {30'd0, exp_ack});
    req[id] = 1'b0;
    while (tx === 1'b0 && n < 20000) begin
      n++;
      tick();
    end
    chk({tag, " start len"}, n, exp_div);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst   = 1'b1;
    baud  = 17'd9600;
    req   = 2'b00;
    data0 = 8'h00;
    data1 = 8'h00;
    #1;
    chk("rst tx", {31'd0, tx}, 32'd1);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst ack", {30'd0, ack}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst done_id", {31'd0, done_id}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle tx", {31'd0, tx}, 32'd1);

    // 9600 frame of 0xA5, with a short-lived request from requester 1.
    data0 = 8'hA5;
    data1 = 8'h3C;
    req   = 2'b01;
    frame("a5", 0, 8'hA5, 5208, 17'd9600, 1'b1);
    tick();
    tick();
    chk("dropped req ack", {30'd0, ack}, 32'd0);
    chk("dropped req busy", {31'd0, busy}, 32'd0);

    // Tie after reset: 0 then 1 back-to-back, then 0 again at new baud.
    do_reset();
    baud  = 17'd57600;
    data0 = 8'h00;
    data1 = 8'hFF;
    req   = 2'b11;
    frame("tie f0", 0, 8'h00, 868, 17'd57600, 1'b0);
    chk("b2b req pending", {30'd0, req}, 32'd2);
    frame("tie f1", 1, 8'hFF, 868, 17'd4800, 1'b0);
    data0 = 8'h01;
    req   = 2'b11;
    start_len("tie again 4800", 0, 10416);

    // Unlisted baud falls back to 5208.
    rst = 1'b1;
    req = 2'b00;
    do_reset();
    baud  = 17'd12345;
    data0 = 8'h01;
    req   = 2'b01;
    start_len("baud 12345", 0, 5208);

    // Reset during data bit 3 with requester 1 waiting.
    do_reset();
    baud  = 17'd57600;
    data0 = 8'h00;
    req   = 2'b01;
    tick();
    chk("abort ack", {30'd0, ack}, 32'd1);
    req = 2'b10;
    repeat (4 * 868 + 10) tick();
    chk("abort pre tx", {31'd0, tx}, 32'd0);
    rst = 1'b1;
    #1;
    chk("abort tx", {31'd0, tx}, 32'd1);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    tick();
    chk("abort hold ack", {30'd0, ack}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post rst ack", {30'd0, ack}, 32'd2);
    chk("post rst busy", {31'd0, busy}, 32'd1);
    chk("post rst done", {31'd0, done}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
